// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source select
// and instruction size.
package pc_pkg;

   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_JR,
      SEL_RET
   } pc_sel_e;

endpackage : pc_pkg

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and sticky overflow/underflow flags record misuse.
module ret_addr_stack #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full,
   output logic            overflow,
   output logic            underflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   top_idx;
   logic [PW-1:0]   wr_idx;
   logic [CW-1:0]   count;

   // ptr addresses the next free slot; once full it wraps onto the oldest entry
   assign top_idx = ptr - PW'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);
   assign full    = (count == CW'(RAS_DEPTH));

   // A simultaneous pop and push on a non-empty stack rewrites the top in place
   assign wr_idx = (pop && !empty) ? top_idx : ptr;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_idx] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (pop && push) begin
         if (empty) begin
            underflow <= 1'b1;
            ptr       <= ptr + PW'(1);
            count     <= CW'(1);
         end
      end else if (pop) begin
         if (empty) begin
            underflow <= 1'b1;
         end else begin
            ptr   <= top_idx;
            count <= count - CW'(1);
         end
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (full) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule : ret_addr_stack

// File: rtl/pc_unit.sv
// Program-counter unit: picks the next fetch address from sequential, branch,
// jump, register-jump and return sources, backed by a return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            en,
   input  logic            branch,
   input  logic            branch_ne,
   input  logic            zero,
   input  logic [XLEN-1:0] addr_result,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            jr,
   input  logic [XLEN-1:0] jr_target,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] branch_base_addr,
   output logic [XLEN-1:0] pc_plus_4,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_overflow,
   output logic            ras_underflow,
   output logic            misalign
);

   pc_sel_e         sel;
   logic            taken;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;
   logic            bad_align;
   logic [XLEN-1:0] ras_top;

   assign branch_base_addr = pc;
   assign pc_plus_4        = pc + XLEN'(INSTR_BYTES);
   assign taken            = branch & (zero ^ branch_ne);

   always_comb begin
      sel = SEL_SEQ;
      if (ret) begin
         sel = SEL_RET;
      end else if (jr) begin
         sel = SEL_JR;
      end else if (jump) begin
         sel = SEL_JMP;
      end else if (taken) begin
         sel = SEL_BR;
      end
   end

   always_comb begin
      target = pc_plus_4;
      unique case (sel)
         // An empty stack falls back to the register value for the return
         SEL_RET: target = ras_empty ? jr_target : ras_top;
         SEL_JR:  target = jr_target;
         SEL_JMP: target = jump_target;
         SEL_BR:  target = addr_result;
         default: target = pc_plus_4;
      endcase
   end

   always_comb begin
      if (sel == SEL_SEQ) begin
         next_pc   = pc_plus_4;
         bad_align = 1'b0;
      end else begin
         next_pc   = {target[XLEN-1:2], 2'b00};
         bad_align = (target[1:0] != 2'b00);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_VECTOR;
         misalign <= 1'b0;
      end else if (en) begin
         pc       <= next_pc;
         misalign <= bad_align;
      end else begin
         misalign <= 1'b0;
      end
   end

   ret_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (en & call),
      .pop       (en & ret),
      .push_data (pc_plus_4),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the PC and return-address stack.
module tb_pc_unit;

   localparam int unsigned    DEPTH = 4;
   localparam logic [31:0]    RV    = 32'h100;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        en, branch, branch_ne, zero, jump, jr, call, ret;
   logic [31:0] addr_result, jump_target, jr_target;
   logic [31:0] pc, branch_base_addr, pc_plus_4;
   logic        ras_empty, ras_full, ras_overflow, ras_underflow, misalign;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_ovf, m_unf, m_mis;

   always #5 clock = ~clock;

   pc_unit #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .en               (en),
      .branch           (branch),
      .branch_ne        (branch_ne),
      .zero             (zero),
      .addr_result      (addr_result),
      .jump             (jump),
      .jump_target      (jump_target),
      .jr               (jr),
      .jr_target        (jr_target),
      .call             (call),
      .ret              (ret),
      .pc               (pc),
      .branch_base_addr (branch_base_addr),
      .pc_plus_4        (pc_plus_4),
      .ras_empty        (ras_empty),
      .ras_full         (ras_full),
      .ras_overflow     (ras_overflow),
      .ras_underflow    (ras_underflow),
      .misalign         (misalign)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RV;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_mis = 1'b0;
   endtask

   // Behavioural next state from the current model state and driven inputs
   task automatic model_step();
      logic [31:0] tgt;
      logic [31:0] ret_addr;
      bit          nonseq;
      ret_addr = m_pc + 32'd4;
      m_mis    = 1'b0;
      tgt      = '0;
      if (en) begin
         nonseq = 1'b1;
         if (ret) begin
            if (m_ras.size() > 0) tgt = m_ras[m_ras.size()-1];
            else begin
               tgt   = jr_target;
               m_unf = 1'b1;
            end
         end else if (jr) tgt = jr_target;
         else if (jump) tgt = jump_target;
         else if (branch && (zero != branch_ne)) tgt = addr_result;
         else nonseq = 1'b0;

         if (ret && call) begin
            if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret_addr;
            else m_ras.push_back(ret_addr);
         end else if (ret) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
         end else if (call) begin
            if (m_ras.size() == DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
            m_ras.push_back(ret_addr);
         end

         if (nonseq) begin
            m_mis = (tgt[1:0] != 2'b00);
            m_pc  = tgt & 32'hFFFF_FFFC;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_all();
      check("pc", pc, m_pc);
      check("branch_base_addr", branch_base_addr, m_pc);
      check("pc_plus_4", pc_plus_4, m_pc + 32'd4);
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
      check("misalign", 32'(misalign), 32'(m_mis));
   endtask

   task automatic cycle(input logic e, input logic b, input logic bn, input logic z,
                        input logic [31:0] ar, input logic j, input logic [31:0] jt,
                        input logic r, input logic [31:0] rt, input logic c, input logic rr);
      en = e; branch = b; branch_ne = bn; zero = z; addr_result = ar;
      jump = j; jump_target = jt; jr = r; jr_target = rt; call = c; ret = rr;
      model_step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic seq_cycle();
      cycle(1, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
   endtask

   task automatic jmp(input logic [31:0] t, input logic c);
      cycle(1, 0, 0, 0, '0, 1, t, 0, '0, c, 0);
   endtask

   task automatic do_ret(input logic [31:0] fallback);
      cycle(1, 0, 0, 0, '0, 0, '0, 0, fallback, 0, 1);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1) == 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      reset_n = 1'b0;
      en = 0; branch = 0; branch_ne = 0; zero = 0; jump = 0; jr = 0; call = 0; ret = 0;
      addr_result = '0; jump_target = '0; jr_target = '0;
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      check("rst_pc", pc, RV);
      check("rst_empty", 32'(ras_empty), 32'd1);
      check("rst_full", 32'(ras_full), 32'd0);
      check("rst_ovf", 32'(ras_overflow), 32'd0);
      check("rst_unf", 32'(ras_underflow), 32'd0);
      check("rst_mis", 32'(misalign), 32'd0);
      reset_n = 1'b1;

      seq_cycle(); check("seq1", pc, 32'h104);
      seq_cycle(); check("seq2", pc, 32'h108);
      seq_cycle(); check("seq3", pc, 32'h10C);
      cycle(0, 0, 0, 0, '0, 1, 32'h999, 0, '0, 1, 0); check("hold1", pc, 32'h10C);
      cycle(0, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0);       check("hold2", pc, 32'h10C);

      cycle(1, 1, 0, 1, 32'h40, 0, '0, 0, '0, 0, 0); check("beq_taken", pc, 32'h40);
      cycle(1, 1, 0, 0, 32'h80, 0, '0, 0, '0, 0, 0); check("beq_not", pc, 32'h44);
      cycle(1, 1, 1, 0, 32'h80, 0, '0, 0, '0, 0, 0); check("bne_taken", pc, 32'h80);
      cycle(1, 1, 1, 1, 32'h40, 0, '0, 0, '0, 0, 0); check("bne_not", pc, 32'h84);

      jmp(32'h200, 0);
      jmp(32'h80, 1);  check("call_pc", pc, 32'h80);
      do_ret(32'h0);   check("ret_pc", pc, 32'h204);
      check("ret_empty", 32'(ras_empty), 32'd1);

      jmp(32'h10, 0);
      jmp(32'h20, 1);
      jmp(32'h30, 1);
      jmp(32'h40, 1);
      jmp(32'h50, 1);
      check("full4", 32'(ras_full), 32'd1);
      jmp(32'h60, 1);
      check("ovf", 32'(ras_overflow), 32'd1);
      do_ret(32'h0); check("ret1", pc, 32'h54);
      do_ret(32'h0); check("ret2", pc, 32'h44);
      do_ret(32'h0); check("ret3", pc, 32'h34);
      do_ret(32'h0); check("ret4", pc, 32'h24);
      do_ret(32'h300); check("ret5_fallback", pc, 32'h300);
      check("unf", 32'(ras_underflow), 32'd1);

      jmp(32'h400, 1);
      cycle(1, 0, 0, 0, '0, 1, 32'h500, 0, '0, 0, 1); check("ret_beats_jump", pc, 32'h304);
      cycle(1, 0, 0, 0, '0, 0, '0, 1, 32'h123, 0, 0);
      check("jr_aligned", pc, 32'h120);
      check("mis_pulse", 32'(misalign), 32'd1);
      seq_cycle(); check("mis_drop", 32'(misalign), 32'd0);

      jmp(32'hFFFF_FFFC, 0);
      seq_cycle(); check("wrap", pc, 32'h0);

      jmp(32'h600, 1);
      jmp(32'h700, 1);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_pc", pc, RV);
      check("async_empty", 32'(ras_empty), 32'd1);
      check("async_ovf", 32'(ras_overflow), 32'd0);
      check("async_unf", 32'(ras_underflow), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(9) != 0), ($urandom_range(9) < 3), 1'($urandom_range(1)),
               1'($urandom_range(1)), rand_addr(), ($urandom_range(9) < 2), rand_addr(),
               ($urandom_range(9) == 0), rand_addr(), ($urandom_range(9) < 2),
               ($urandom_range(9) < 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle CPU core, succeeding the fixed 32-bit branch-only PC. Selects the next fetch address from sequential, conditional branch (beq/bne), absolute jump, register jump and return-from-call sources. It also keeps a small circular return-address stack (RAS) so that call/return pairs resolve without a register read. It sits between the controller/ALU and instruction memory and drives the fetch address every cycle.

## Interface
- XLEN, 32: address width in bits (≥ 8).
- RESET_VECTOR, 0: PC value after reset; must be 4-byte aligned.
- RAS_DEPTH, 4: number of RAS entries (power of two, 2..16).
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; when 0, PC and RAS hold and all other inputs are ignored.
- branch  input  1  conditional branch instruction (from controller).
- branch_ne  input  1  branch sense: 0 = beq (taken when zero=1), 1 = bne (taken when zero=0).
- zero  input  1  ALU zero flag.
- addr_result  input  XLEN  branch target computed by ALU.
- jump  input  1  absolute jump (j/jal).
- jump_target  input  XLEN  jump target.
- jr  input  1  register jump.
- jr_target  input  XLEN  register value for jr.
- call  input  1  push PC+4 onto RAS this cycle (with jump or jr).
- ret  input  1  return: take RAS top as target and pop.
- pc  output  XLEN  current fetch address.
- branch_base_addr  output  XLEN  equals pc (combinational copy for ALU target calculation).
- pc_plus_4  output  XLEN  pc + 4, modulo 2^XLEN.
- ras_empty  output  1  RAS holds zero entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_overflow  output  1  sticky: a push occurred while full.
- ras_underflow  output  1  sticky: a ret occurred while empty.
- misalign  output  1  one-cycle pulse: selected target had nonzero bits [1:0].

## Operation
- Next-PC priority (highest first): ret, jr, jump, taken branch, sequential pc+4.
- Branch taken = branch & (zero ^ branch_ne).
- ret with RAS non-empty: target = top entry. ret with RAS empty: target = jr_target, set ras_underflow, count stays 0.
- call pushes pc+4, the return address of the current instruction.
- Push when full: overwrite the oldest entry (circular wrap), count stays RAS_DEPTH, set ras_overflow.
- call and ret in the same enabled cycle: pop then push. The top is replaced by pc+4, count unchanged, and no flag is set unless ret found the stack empty.
- Target alignment: any non-sequential target with bits [1:0] ≠ 0 is loaded with bits [1:0] cleared, and misalign pulses high for that cycle's update.
- All address arithmetic wraps modulo 2^XLEN; pc = 2^XLEN−4 steps to 0.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, reset_n=0) forces: pc=RESET_VECTOR, RAS count 0, RAS pointer 0, ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0, misalign=0. Release is sampled synchronously; the first update occurs on the first rising edge with reset_n=1 and en=1.
- Latency: selection is combinational from inputs and current state; the new pc is visible one clock after the enabled edge.
- misalign is registered: high for exactly the cycle following the offending update.
- en=0 holds everything, and misalign drops to 0.
- Reset asserted mid-stream discards all RAS contents immediately. Entry storage need not be cleared, but it is never read while count = 0.

## Structure
- Package pc_pkg: next-PC select enum (SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR, SEL_RET) and INSTR_BYTES = 4.
- Sub-module ret_addr_stack (params XLEN, RAS_DEPTH): storage, pointer, count, push/pop/overflow/underflow logic. pc_unit holds the select mux, PC register and misalign register.

## Test plan
- Reset with RESET_VECTOR=0x100, then 3 enabled cycles → pc 0x100, 0x104, 0x108, 0x10C. en held low for 2 cycles → pc holds.
- branch=1, branch_ne=0, zero=1, addr_result=0x40 → pc=0x40. Same with zero=0 → pc+4. With branch_ne=1 the outcomes are inverted.
- At pc=0x200: jump=1, call=1, jump_target=0x80 → pc=0x80, RAS top 0x204. Later ret=1 → pc=0x204, ras_empty=1.
- RAS_DEPTH=4: five calls from 0x10, 0x20, 0x30, 0x40, 0x50 → ras_overflow=1. Four rets then return 0x54, 0x44, 0x34, 0x24. A fifth ret → target jr_target, ras_underflow=1.
- jump and ret both asserted with a non-empty RAS → ret wins. jr_target=0x123 with jr=1 → pc=0x120, misalign=1 for one cycle.
- pc=0xFFFFFFFC (XLEN=32) sequential → pc=0. Async reset asserted mid-cycle with 2 RAS entries → pc=RESET_VECTOR and ras_empty=1 before the next edge.
